// File: rtl/dac_ctrl_fsm_4ch_pkg.sv
// Shared sizes, FSM state encoding and frame formatting for the 4-chip HV DAC controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_ctrl_fsm_4ch_pkg;

  localparam int N_DAC      = 4;
  localparam int CH_PER_DAC = 8;
  localparam int DATA_W     = 10;
  localparam int FRAME_W    = 16;
  localparam int N_CH       = N_DAC * CH_PER_DAC;
  localparam int HV_W       = N_CH * DATA_W;
  localparam int SLOT_W     = 3;
  localparam int BIT_W      = 4;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;
  localparam logic [BIT_W-1:0]  LAST_BIT  = 4'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    CS_LOW  = 3'd2,
    SCK_HI  = 3'd3,
    SCK_LO  = 3'd4,
    CS_HIGH = 3'd5,
    LOAD    = 3'd6
  } state_t;

  // Frame layout seen by the DAC: zero, channel address, code, two zero pad bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [SLOT_W-1:0] slot,
                                                     input logic [DATA_W-1:0] code);
    return {1'b0, slot, code, 2'b00};
  endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// One serial lane: holds a 16-bit frame and presents it MSB first on a registered din.
// Latency: din shows frame bit 15 the cycle after load, each shift advances one bit.
// Backpressure: none; the controlling FSM paces load/shift.
module dac_frame_shifter
  import dac_ctrl_fsm_4ch_pkg::*;
(
  input  logic               clkin,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic               clear,
  input  logic [FRAME_W-1:0] frame,
  output logic               din
);

  // sr holds the bits still to be sent after the one currently on din.
  logic [FRAME_W-1:0] sr;

  // Load puts the MSB straight onto din; shift moves the next bit out; clear parks the line low.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      din <= 1'b0;
    end else if (load) begin
      din <= frame[FRAME_W-1];
      sr  <= {frame[FRAME_W-2:0], 1'b0};
    end else if (shift) begin
      din <= sr[FRAME_W-1];
      sr  <= {sr[FRAME_W-2:0], 1'b0};
    end else if (clear) begin
      din <= 1'b0;
      sr  <= '0;
    end
  end

endmodule

// File: rtl/dac_ctrl_fsm_4ch.sv
// Writes the 32 latched HV codes to four 8-channel DACs in parallel, then pulses dac_load.
// Latency: 283 cycles per burst from the detected hv_update rise back to IDLE.
// Backpressure: none; rises seen while busy are merged into one pending re-run.
module dac_ctrl_fsm_4ch
  import dac_ctrl_fsm_4ch_pkg::*;
(
  input  logic              clkin,
  input  logic              reset,
  input  logic              hv_update,
  input  logic [HV_W-1:0]   hv_reg_din,
  input  logic [N_DAC-1:0]  dac_dout,
  output logic [N_DAC-1:0]  dac_sclk,
  output logic [N_DAC-1:0]  dac_din,
  output logic [N_DAC-1:0]  dac_cs,
  output logic              dac_load
);

  state_t                      state, state_nxt;
  logic                        hv_q, hv_q_d, rise;
  logic [N_DAC-1:0]            dout_s1, dout_s2;
  logic                        dout_seen;
  logic [BIT_W-1:0]            bit_cnt;
  logic [SLOT_W-1:0]           slot;
  logic                        gap_cnt;
  logic                        pending;
  logic [HV_W-1:0]             shadow;
  logic [SLOT_W-1:0]           frame_slot;
  logic [N_DAC-1:0][FRAME_W-1:0] frame;
  logic                        sh_load, sh_shift, sh_clear;
  logic                        in_window;

  // Register the update request once and take its rising edge.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      hv_q   <= 1'b0;
      hv_q_d <= 1'b0;
    end else begin
      hv_q   <= hv_update;
      hv_q_d <= hv_q;
    end
  end

  assign rise = hv_q & ~hv_q_d;

  // Readback lines are only synchronised for now; the sticky flag keeps them alive for a later status bit.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      dout_s1   <= '0;
      dout_s2   <= '0;
      dout_seen <= 1'b0;
    end else begin
      dout_s1   <= dac_dout;
      dout_s2   <= dout_s1;
      dout_seen <= dout_seen | (|dout_s2);
    end
  end

  // State register.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; gap_cnt marks the second cycle of the two-cycle CS_HIGH and LOAD phases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise || pending) state_nxt = LATCH;
      LATCH:   state_nxt = CS_LOW;
      CS_LOW:  state_nxt = SCK_HI;
      SCK_HI:  state_nxt = SCK_LO;
      SCK_LO:  state_nxt = (bit_cnt == LAST_BIT) ? CS_HIGH : SCK_HI;
      CS_HIGH: begin
        if (gap_cnt) state_nxt = (slot == LAST_SLOT) ? LOAD : CS_LOW;
      end
      LOAD: begin
        if (gap_cnt) state_nxt = (pending || rise) ? LATCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit, slot and gap counters plus the merged pending request.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      slot    <= '0;
      gap_cnt <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (state == SCK_LO)      bit_cnt <= bit_cnt + 4'd1;
      else if (state == CS_LOW) bit_cnt <= '0;

      if (state == LATCH)                   slot <= '0;
      else if (state == CS_HIGH && gap_cnt) slot <= slot + 3'd1;

      if (state == CS_HIGH || state == LOAD) gap_cnt <= ~gap_cnt;
      else                                   gap_cnt <= 1'b0;

      // The LOAD exit consumes both the pending flag and a rise arriving in that same cycle.
      if (state == LOAD && gap_cnt)       pending <= 1'b0;
      else if (rise && state != IDLE)     pending <= 1'b1;
    end
  end

  // Snapshot the HV register on the way into LATCH so the burst sees stable codes.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (state_nxt == LATCH) begin
      shadow <= hv_reg_din;
    end
  end

  // The frame is loaded on entry to CS_LOW, so select the slot that is about to start.
  assign frame_slot = (state == CS_HIGH) ? slot + 3'd1 : '0;

  // Build each chip's frame: chip d, slot c carries channel 8d+c.
  always_comb begin
    frame = '0;
    for (int d = 0; d < N_DAC; d++) begin
      frame[d] = build_frame(frame_slot,
                             shadow[(d * CH_PER_DAC + int'(frame_slot)) * DATA_W +: DATA_W]);
    end
  end

  assign in_window = (state_nxt == CS_LOW) || (state_nxt == SCK_HI) || (state_nxt == SCK_LO);
  assign sh_load   = (state_nxt == CS_LOW);
  assign sh_shift  = (state_nxt == SCK_LO);
  assign sh_clear  = ~in_window;

  for (genvar d = 0; d < N_DAC; d++) begin : g_lane
    dac_frame_shifter u_shifter (
      .clkin (clkin),
      .reset (reset),
      .load  (sh_load),
      .shift (sh_shift),
      .clear (sh_clear),
      .frame (frame[d]),
      .din   (dac_din[d])
    );
  end

  // Pin outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      dac_sclk <= '0;
      dac_cs   <= '1;
      dac_load <= 1'b1;
    end else begin
      dac_sclk <= (state_nxt == SCK_HI) ? '1 : '0;
      dac_cs   <= in_window ? '0 : '1;
      dac_load <= (state_nxt != LOAD);
    end
  end

endmodule

// File: tb/tb_dac_ctrl_fsm_4ch.sv
`timescale 1ns/1ps
module tb_dac_ctrl_fsm_4ch;

  logic         clkin = 1'b0;
  logic         reset = 1'b0;
  logic         hv_update = 1'b0;
  logic [319:0] hv_reg_din = '0;
  logic [3:0]   dac_dout = '0;
  logic [3:0]   dac_sclk, dac_din, dac_cs;
  logic         dac_load;

  dac_ctrl_fsm_4ch dut (
    .clkin      (clkin),
    .reset      (reset),
    .hv_update  (hv_update),
    .hv_reg_din (hv_reg_din),
    .dac_dout   (dac_dout),
    .dac_sclk   (dac_sclk),
    .dac_din    (dac_din),
    .dac_cs     (dac_cs),
    .dac_load   (dac_load)
  );

  always #500 clkin = ~clkin;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor, sampled on the falling edge.
  logic [15:0] cap [0:3][0:127];
  int          rises [0:127];
  int          wstart [0:127];
  int          wend [0:127];
  int          lfall [0:15];
  int          lrise [0:15];
  int          llen [0:15];
  logic [15:0] shr [0:3];
  int          cyc = 0, n_win = 0, n_wstart = 0, n_load = 0, rcnt = 0, lcur = 0, n_misalign = 0;
  logic        prev_cs0 = 1'b1, prev_sclk0 = 1'b0, prev_load = 1'b1;

  initial begin
    forever begin
      @(negedge clkin);
      cyc++;
      dac_dout = 4'($urandom_range(0, 15));
      if ((dac_sclk != 4'h0 && dac_sclk != 4'hF) || (dac_cs != 4'h0 && dac_cs != 4'hF))
        n_misalign++;
      if (!dac_cs[0] && prev_cs0) begin
        if (n_wstart < 128) wstart[n_wstart] = cyc;
        n_wstart++;
        rcnt = 0;
        for (int d = 0; d < 4; d++) shr[d] = '0;
      end
      if (dac_sclk[0] && !prev_sclk0) begin
        for (int d = 0; d < 4; d++) shr[d] = {shr[d][14:0], dac_din[d]};
        if (!dac_cs[0]) rcnt++;
      end
      if (dac_cs[0] && !prev_cs0) begin
        if (n_win < 128) begin
          for (int d = 0; d < 4; d++) cap[d][n_win] = shr[d];
          rises[n_win] = rcnt;
          wend[n_win]  = cyc;
        end
        n_win++;
      end
      if (!dac_load) lcur++;
      if (!dac_load && prev_load && n_load < 16) lfall[n_load] = cyc;
      if (dac_load && !prev_load) begin
        if (n_load < 16) begin
          lrise[n_load] = cyc;
          llen[n_load]  = lcur;
        end
        n_load++;
        lcur = 0;
      end
      prev_cs0   = dac_cs[0];
      prev_sclk0 = dac_sclk[0];
      prev_load  = dac_load;
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [319:0] pat_inc();
    logic [319:0] v;
    for (int k = 0; k < 32; k++) v[k*10 +: 10] = 10'(k + 1);
    return v;
  endfunction

  function automatic logic [319:0] pat_rev();
    logic [319:0] v;
    for (int k = 0; k < 32; k++) v[k*10 +: 10] = 10'(1023 - k);
    return v;
  endfunction

  function automatic logic [15:0] exp_frame(input logic [319:0] v, input int d, input int c);
    logic [2:0] c3;
    c3 = 3'(c);
    return {1'b0, c3, v[(8*d + c)*10 +: 10], 2'b00};
  endfunction

  task automatic pulse_update(output int dcyc);
    @(posedge clkin);
    #1 hv_update = 1'b1;
    dcyc = cyc;
    repeat (2) @(posedge clkin);
    #1 hv_update = 1'b0;
  endtask

  task automatic wait_loads(input int target, input int budget, input string tag);
    int i = 0;
    while (n_load < target && i < budget) begin
      @(negedge clkin);
      i++;
    end
    chk(tag, 32'(n_load >= target), 32'd1);
  endtask

  task automatic wait_wstart(input int target, input int budget, input string tag);
    int i = 0;
    while (n_wstart < target && i < budget) begin
      @(negedge clkin);
      i++;
    end
    chk(tag, 32'(n_wstart >= target), 32'd1);
  endtask

  task automatic chk_burst(input string tag, input int w, input logic [319:0] v);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s_c%0ds%0d", tag, d, c), 32'(cap[d][w + c]), 32'(exp_frame(v, d, c)));
  endtask

  initial begin
    int w0, l0, d0, ws, ln;
    logic [319:0] v;

    // 1: reset state and quiet idle
    @(negedge clkin);
    chk("rst_sclk", 32'(dac_sclk), 32'h0);
    chk("rst_din",  32'(dac_din),  32'h0);
    chk("rst_cs",   32'(dac_cs),   32'hF);
    chk("rst_load", 32'(dac_load), 32'h1);
    @(posedge clkin);
    #1 reset = 1'b1;
    ws = n_wstart;
    repeat (5) @(negedge clkin);
    chk("idle_sclk", 32'(dac_sclk), 32'h0);
    chk("idle_cs",   32'(dac_cs),   32'hF);
    chk("idle_load", 32'(dac_load), 32'h1);
    chk("idle_nowin", 32'(n_wstart), 32'(ws));

    // 2/3: ramp pattern, frame contents and burst timing
    hv_reg_din = pat_inc();
    w0 = n_win; l0 = n_load;
    pulse_update(d0);
    hv_reg_din = '0;
    wait_loads(l0 + 1, 400, "t2_done");
    chk("t2_c0s0", 32'(cap[0][w0]), 32'h0004);
    chk("t2_c3s7", 32'(cap[3][w0 + 7]), 32'h7080);
    chk("t2_windows", 32'(n_win - w0), 32'd8);
    for (int s = 0; s < 8; s++) chk($sformatf("t2_rises%0d", s), 32'(rises[w0 + s]), 32'd16);
    chk_burst("t2", w0, pat_inc());
    chk("t3_first_cs", 32'(wstart[w0] - d0), 32'd4);
    chk("t3_frame_period", 32'(wstart[w0 + 1] - wstart[w0]), 32'd35);
    chk("t3_load_after_cs", 32'(lfall[l0] - wend[w0 + 7]), 32'd2);
    chk("t3_load_len", 32'(llen[l0]), 32'd2);
    chk("t3_burst_len", 32'(lrise[l0] - wstart[w0] + 1), 32'd283);

    // 4: single full-scale channel
    v = '0;
    v[130 +: 10] = 10'h3FF;
    hv_reg_din = v;
    w0 = n_win; l0 = n_load;
    pulse_update(d0);
    wait_loads(l0 + 1, 400, "t4_done");
    chk("t4_c1s5", 32'(cap[1][w0 + 5]), 32'h5FFC);
    chk("t4_c0s5", 32'(cap[0][w0 + 5]), 32'h5000);
    chk("t4_c2s5", 32'(cap[2][w0 + 5]), 32'h5000);
    chk("t4_c3s5", 32'(cap[3][w0 + 5]), 32'h5000);
    chk("t4_c1s4", 32'(cap[1][w0 + 4]), 32'h4000);

    // 5a: one rise during slot 3 with new data -> one extra burst
    hv_reg_din = pat_inc();
    w0 = n_win; l0 = n_load; ws = n_wstart;
    pulse_update(d0);
    wait_wstart(ws + 4, 300, "t5_slot3");
    hv_reg_din = pat_rev();
    pulse_update(d0);
    wait_loads(l0 + 2, 800, "t5_two_loads");
    chk_burst("t5a", w0, pat_inc());
    chk_burst("t5b", w0 + 8, pat_rev());
    chk("t5_rearm_gap", 32'(wstart[ws + 8] - lrise[l0]), 32'd1);
    repeat (320) @(negedge clkin);
    chk("t5_no_third", 32'(n_load), 32'(l0 + 2));

    // 5b: two rises in one burst merge into one re-run using the latest data
    hv_reg_din = pat_inc();
    w0 = n_win; l0 = n_load; ws = n_wstart;
    pulse_update(d0);
    wait_wstart(ws + 3, 300, "t5m_slot2");
    hv_reg_din = pat_rev();
    pulse_update(d0);
    wait_wstart(ws + 6, 300, "t5m_slot5");
    v = '0;
    for (int k = 0; k < 32; k++) v[k*10 +: 10] = 10'h155;
    hv_reg_din = v;
    pulse_update(d0);
    wait_loads(l0 + 2, 800, "t5m_two_loads");
    repeat (320) @(negedge clkin);
    chk("t5m_loads", 32'(n_load), 32'(l0 + 2));
    chk("t5m_windows", 32'(n_win - w0), 32'd16);
    chk("t5m_c2s3", 32'(cap[2][w0 + 11]), 32'(exp_frame(v, 2, 3)));

    // 6: reset in slot 4 aborts without a load pulse
    hv_reg_din = pat_inc();
    l0 = n_load; ws = n_wstart;
    pulse_update(d0);
    wait_wstart(ws + 5, 300, "t6_slot4");
    repeat (7) @(negedge clkin);
    #100 reset = 1'b0;
    #1;
    chk("t6_abort_cs",   32'(dac_cs),   32'hF);
    chk("t6_abort_load", 32'(dac_load), 32'h1);
    chk("t6_abort_sclk", 32'(dac_sclk), 32'h0);
    chk("t6_abort_din",  32'(dac_din),  32'h0);
    repeat (3) @(negedge clkin);
    @(posedge clkin);
    #1 reset = 1'b1;
    ws = n_wstart;
    repeat (300) @(negedge clkin);
    chk("t6_no_load", 32'(n_load), 32'(l0));
    chk("t6_idle_nowin", 32'(n_wstart), 32'(ws));
    chk("t6_idle_cs", 32'(dac_cs), 32'hF);
    w0 = n_win;
    pulse_update(d0);
    wait_loads(l0 + 1, 400, "t6_restart");
    chk("t6_c0s0", 32'(cap[0][w0]), 32'h0004);
    chk("t6_c3s7", 32'(cap[3][w0 + 7]), 32'h7080);

    chk("lane_align", 32'(n_misalign), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
